// File: rtl/acondicionador_botones.sv
// -----------------------------------------------------------------------------
// acondicionador_botones
//   Turns two raw, bouncy, asynchronous push-button levels (food / medicine)
//   into clean registered events for the pet state/mode machine:
//     - Estable_*  : debounced button level
//     - Pulso_*    : one-cycle short-press event, emitted as the level falls
//     - Largo_*    : one-cycle long-press event once held LONG_CYCLES
//   Both channels are identical and independent.
//
//   Ports:
//     clk                 system clock
//     reset               asynchronous active-high reset
//     Boton_Comida_raw    raw food button, 1 = pressed
//     Boton_Medicina_raw  raw medicine button, 1 = pressed
//     Estable_Comida/Medicina, Pulso_Comida/Medicina, Largo_Comida/Medicina
//
//   Optional feature macro: AUTOREPEAT_EN
//     When defined, a held long press re-fires Largo every REPEAT_CYCLES.
// -----------------------------------------------------------------------------

// One button channel: 2-flop synchronizer + debounce / hold FSM.
module acondicionador_canal #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LONG_CYCLES     = 20,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic estable,
    output logic pulso,
    output logic largo
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(LONG_CYCLES) + 1;
    localparam logic [DW-1:0] DEB_ULT  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_ULT = HW'(LONG_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_invalid
        $error("acondicionador_canal: invalid cycle parameters");
    end

    typedef enum logic [2:0] {
        REPOSO,
        FILTRO_ALTO,
        PRESIONADO,
        LARGO,
        FILTRO_BAJO
    } estado_t;

    logic            s1_q, s2_q;
    logic            s;
    estado_t         estado_q, estado_d;
    logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            fue_largo_q, fue_largo_d;
    logic            estable_q, estable_d;
    logic            pulso_q, pulso_d;
    logic            largo_q, largo_d;
`ifdef AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RW-1:0] REP_ULT = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0]   rep_cnt_q, rep_cnt_d;
`endif

    assign s = s2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            estado_q    <= REPOSO;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            fue_largo_q <= 1'b0;
            estable_q   <= 1'b0;
            pulso_q     <= 1'b0;
            largo_q     <= 1'b0;
`ifdef AUTOREPEAT_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            s1_q        <= raw;
            s2_q        <= s1_q;
            estado_q    <= estado_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            fue_largo_q <= fue_largo_d;
            estable_q   <= estable_d;
            pulso_q     <= pulso_d;
            largo_q     <= largo_d;
`ifdef AUTOREPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
`endif
        end
    end

    always_comb begin
        estado_d    = estado_q;
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        fue_largo_d = fue_largo_q;
        estable_d   = estable_q;
        pulso_d     = 1'b0;
        largo_d     = 1'b0;
`ifdef AUTOREPEAT_EN
        rep_cnt_d   = rep_cnt_q;
`endif
        case (estado_q)
            REPOSO: begin
                estable_d = 1'b0;
                if (s) begin
                    estado_d  = FILTRO_ALTO;
                    deb_cnt_d = '0;
                end
            end
            FILTRO_ALTO: begin
                if (!s) begin
                    estado_d = REPOSO;
                end else if (deb_cnt_q == DEB_ULT) begin
                    estado_d    = PRESIONADO;
                    estable_d   = 1'b1;
                    hold_cnt_d  = '0;
                    fue_largo_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            PRESIONADO: begin
                if (!s) begin
                    estado_d  = FILTRO_BAJO;
                    deb_cnt_d = '0;
                end else if (hold_cnt_q == LONG_ULT) begin
                    estado_d    = LARGO;
                    fue_largo_d = 1'b1;
                    largo_d     = 1'b1;
`ifdef AUTOREPEAT_EN
                    rep_cnt_d   = '0;
`endif
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            LARGO: begin
                if (!s) begin
                    estado_d  = FILTRO_BAJO;
                    deb_cnt_d = '0;
                end
`ifdef AUTOREPEAT_EN
                else if (rep_cnt_q == REP_ULT) begin
                    largo_d   = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
`endif
            end
            FILTRO_BAJO: begin
                // A bounce back to 1 resumes the press; hold/repeat counters
                // were frozen here so only the low cycles shift the timing.
                if (s) begin
                    estado_d = fue_largo_q ? LARGO : PRESIONADO;
                end else if (deb_cnt_q == DEB_ULT) begin
                    estado_d  = REPOSO;
                    estable_d = 1'b0;
                    pulso_d   = !fue_largo_q;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: estado_d = REPOSO;
        endcase
    end

    assign estable = estable_q;
    assign pulso   = pulso_q;
    assign largo   = largo_q;
endmodule

module acondicionador_botones #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LONG_CYCLES     = 20,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic Boton_Comida_raw,
    input  logic Boton_Medicina_raw,
    output logic Estable_Comida,
    output logic Estable_Medicina,
    output logic Pulso_Comida,
    output logic Pulso_Medicina,
    output logic Largo_Comida,
    output logic Largo_Medicina
);
    acondicionador_canal #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .LONG_CYCLES    (LONG_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_comida (
        .clk    (clk),
        .reset  (reset),
        .raw    (Boton_Comida_raw),
        .estable(Estable_Comida),
        .pulso  (Pulso_Comida),
        .largo  (Largo_Comida)
    );

    acondicionador_canal #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .LONG_CYCLES    (LONG_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_medicina (
        .clk    (clk),
        .reset  (reset),
        .raw    (Boton_Medicina_raw),
        .estable(Estable_Medicina),
        .pulso  (Pulso_Medicina),
        .largo  (Largo_Medicina)
    );
endmodule
